// File: rtl/ascon_host_seq.sv
// Initiator-side sequencer for the Ascon core controller.
// Streams AD then DI blocks from the input buffer to the core, writes every
// returned output block to the output buffer, captures the tag and reports
// completion or abort.
module ascon_host_seq #(
  parameter int SIZE_WIDTH = 8,
  parameter int MEM_AW     = 5,
  parameter int TAG_W      = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  go_i,
  input  logic                  abort_i,
  input  logic [SIZE_WIDTH-1:0] ad_size_i,
  input  logic [SIZE_WIDTH-1:0] di_size_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  aborted_o,
  output logic                  mem_rd_en_o,
  output logic [MEM_AW-1:0]     mem_rd_addr_o,
  input  logic [63:0]           mem_rd_data_i,
  output logic                  out_we_o,
  output logic [MEM_AW-1:0]     out_addr_o,
  output logic [63:0]           out_data_o,
  output logic                  core_start_o,
  output logic [SIZE_WIDTH-1:0] core_ad_size_o,
  output logic [SIZE_WIDTH-1:0] core_di_size_o,
  output logic [63:0]           core_data_o,
  output logic                  core_data_valid_o,
  input  logic                  core_data_ready_i,
  input  logic [63:0]           core_data_i,
  input  logic                  core_data_valid_i,
  input  logic [TAG_W-1:0]      core_tag_i,
  input  logic                  core_tag_valid_i,
  input  logic                  core_idle_i,
  output logic [TAG_W-1:0]      tag_o,
  output logic                  tag_valid_o
);

  // Block counter must hold n_ad+n_di and also cover the full address range.
  localparam int CW = (SIZE_WIDTH - 1 > MEM_AW) ? SIZE_WIDTH - 1 : MEM_AW;

  typedef enum logic [3:0] {
    S_IDLE, S_SETUP, S_START, S_FETCH, S_LOAD,
    S_PRESENT, S_TAGWAIT, S_FINISH, S_DRAIN
  } state_t;

  state_t                state;
  logic [SIZE_WIDTH-3:0] n_ad;
  logic [SIZE_WIDTH-3:0] n_di;
  logic [CW-1:0]         blk_cnt;
  logic [CW-1:0]         blk_next;
  logic [CW-1:0]         blk_total;
  logic [MEM_AW-1:0]     out_cnt;
  logic                  capture;

  // Ceiling of bytes/8: whole 8-byte blocks plus one for any partial tail.
  function automatic logic [SIZE_WIDTH-3:0] blocks_of(input logic [SIZE_WIDTH-1:0] sz);
    return {1'b0, sz[SIZE_WIDTH-1:3]} + (SIZE_WIDTH-2)'(|sz[2:0]);
  endfunction

  // Block bookkeeping and the same-cycle output-buffer write path.
  always_comb begin
    blk_total  = CW'(n_ad) + CW'(n_di);
    blk_next   = blk_cnt + CW'(1);
    capture    = (state != S_IDLE) && (state != S_SETUP);
    out_we_o   = capture && core_data_valid_i;
    out_addr_o = out_cnt;
    out_data_o = out_we_o ? core_data_i : '0;
  end

  // Sequencer FSM with registered outputs; abort takes priority over every
  // other event in any active state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      n_ad              <= '0;
      n_di              <= '0;
      blk_cnt           <= '0;
      out_cnt           <= '0;
      busy_o            <= 1'b0;
      done_o            <= 1'b0;
      aborted_o         <= 1'b0;
      mem_rd_en_o       <= 1'b0;
      mem_rd_addr_o     <= '0;
      core_start_o      <= 1'b0;
      core_ad_size_o    <= '0;
      core_di_size_o    <= '0;
      core_data_o       <= '0;
      core_data_valid_o <= 1'b0;
      tag_o             <= '0;
      tag_valid_o       <= 1'b0;
    end else begin
      if (out_we_o)
        out_cnt <= out_cnt + MEM_AW'(1);

      if (abort_i && state != S_IDLE && state != S_DRAIN) begin
        core_start_o      <= 1'b0;
        core_data_valid_o <= 1'b0;
        mem_rd_en_o       <= 1'b0;
        done_o            <= 1'b0;
        state             <= S_DRAIN;
      end else begin
        case (state)
          S_IDLE: begin
            aborted_o <= 1'b0;
            if (go_i) begin
              core_ad_size_o <= ad_size_i;
              core_di_size_o <= di_size_i;
              tag_valid_o    <= 1'b0;
              busy_o         <= 1'b1;
              state          <= S_SETUP;
            end
          end
          S_SETUP: begin
            n_ad         <= blocks_of(core_ad_size_o);
            n_di         <= blocks_of(core_di_size_o);
            blk_cnt      <= '0;
            out_cnt      <= '0;
            core_start_o <= 1'b1;
            state        <= S_START;
          end
          S_START: begin
            if (blk_total == '0) begin
              state <= S_TAGWAIT;
            end else begin
              mem_rd_en_o   <= 1'b1;
              mem_rd_addr_o <= blk_cnt[MEM_AW-1:0];
              state         <= S_FETCH;
            end
          end
          S_FETCH: begin
            mem_rd_en_o <= 1'b0;
            state       <= S_LOAD;
          end
          S_LOAD: begin
            core_data_o       <= mem_rd_data_i;
            core_data_valid_o <= 1'b1;
            state             <= S_PRESENT;
          end
          S_PRESENT: begin
            if (core_data_valid_o && core_data_ready_i) begin
              core_data_valid_o <= 1'b0;
              blk_cnt           <= blk_next;
              if (blk_next < blk_total) begin
                mem_rd_en_o   <= 1'b1;
                mem_rd_addr_o <= blk_next[MEM_AW-1:0];
                state         <= S_FETCH;
              end else begin
                state <= S_TAGWAIT;
              end
            end
          end
          S_TAGWAIT: begin
            if (core_tag_valid_i) begin
              tag_o        <= core_tag_i;
              tag_valid_o  <= 1'b1;
              core_start_o <= 1'b0;
              done_o       <= 1'b1;
              state        <= S_FINISH;
            end
          end
          S_FINISH: begin
            done_o <= 1'b0;
            busy_o <= 1'b0;
            state  <= S_IDLE;
          end
          S_DRAIN: begin
            if (core_idle_i) begin
              aborted_o <= 1'b1;
              busy_o    <= 1'b0;
              state     <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/ascon_host_seq.md
Name: ascon_host_seq

Overview:
- Initiator-side sequencer for the Ascon core controller: raises start, streams associated-data (AD) and input-data (DI) blocks to the core over a valid/ready handshake, and writes each returned output block to an output buffer.
- Captures the tag and signals completion.
- Sits between the subsystem register/buffer layer and the Ascon core.
- Replaces software polling of the core handshake.

Parameters:
- SIZE_WIDTH, 8, width of AD/DI byte-size fields.
- MEM_AW, 5, address width of the input block buffer and the output block buffer.
- TAG_W, 128, tag width.
- Block width is fixed at 64 bits (8 bytes).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- go_i  in  1  one-cycle request to run one operation; ignored unless idle
- abort_i  in  1  level; cancels a running operation
- ad_size_i  in  SIZE_WIDTH  AD length in bytes; sampled on accepted go_i
- di_size_i  in  SIZE_WIDTH  DI length in bytes; sampled on accepted go_i
- busy_o  out  1  operation in progress
- done_o  out  1  one-cycle completion pulse
- aborted_o  out  1  one-cycle abort-complete pulse
- mem_rd_en_o  out  1  input buffer read strobe
- mem_rd_addr_o  out  MEM_AW  input buffer read address
- mem_rd_data_i  in  64  read data; valid exactly 1 cycle after the strobe
- out_we_o  out  1  output buffer write strobe
- out_addr_o  out  MEM_AW  output buffer write address
- out_data_o  out  64  output buffer write data
- core_start_o  out  1  start level to the core
- core_ad_size_o  out  SIZE_WIDTH  latched AD size
- core_di_size_o  out  SIZE_WIDTH  latched DI size
- core_data_o  out  64  block presented to the core
- core_data_valid_o  out  1  block valid
- core_data_ready_i  in  1  core ready for a block
- core_data_i  in  64  output block from the core
- core_data_valid_i  in  1  one-cycle output-block pulse
- core_tag_i  in  TAG_W  tag from the core
- core_tag_valid_i  in  1  tag valid level
- core_idle_i  in  1  core idle
- tag_o  out  TAG_W  latched tag
- tag_valid_o  out  1  tag_o holds the tag of the last completed operation

Behaviour:
- Reset values: all outputs 0, tag_o 0, FSM in Idle.
- Block counts, computed in Setup at SIZE_WIDTH-2 bits:
  - n_ad = (ad_size + 7) >> 3
  - n_di = (di_size + 7) >> 3
- Input buffer layout: AD blocks at addresses 0..n_ad-1, DI blocks at n_ad..n_ad+n_di-1.
- Output buffer: block k is written to address k, for k = 0..n_di-1.
- Addresses truncate to MEM_AW bits (wrap-around); sizing the buffers is the integrator's responsibility.
- FSM states and transitions:
  - Idle: go_i=1 -> Setup. On that edge, latch sizes, clear tag_valid_o, busy_o=1.
  - Setup: compute n_ad and n_di, clear block and output counters -> Start.
  - Start: core_start_o=1 (held until Finish or Idle). If n_ad+n_di=0 -> TagWait, else -> Fetch.
  - Fetch: mem_rd_en_o=1 with addr = block counter -> Load.
  - Load: register mem_rd_data_i into core_data_o, set core_data_valid_o=1 -> Present.
  - Present: hold core_data_o and core_data_valid_o stable. When core_data_valid_o & core_data_ready_i, the transfer occurs: next cycle valid=0 and the block counter increments. Then -> Fetch if blocks remain, else -> TagWait.
  - TagWait: core_tag_valid_i=1 -> latch tag_o, set tag_valid_o=1 -> Finish.
  - Finish: core_start_o=0, done_o=1 for one cycle, busy_o=0 -> Idle.
- Output capture runs in parallel with every state except Idle and Setup:
  - Each core_data_valid_i pulse gives out_we_o=1 in the same cycle, out_data_o=core_data_i, out_addr_o = output counter. The counter then increments.
  - Pulses beyond n_di are still written, at the wrapped address.
- Throughput: a block transfer costs at least 3 cycles (Fetch, Load, Present). The core's round latency dominates.
- Abort: abort_i=1 in any state other than Idle:
  - Next cycle: core_start_o=0, core_data_valid_o=0 -> Drain.
  - Drain: wait for core_idle_i=1, then aborted_o pulse, busy_o=0 -> Idle. tag_valid_o stays 0.
  - abort_i in Idle is ignored.
  - If abort_i and core_tag_valid_i arrive in the same cycle, abort wins.
- go_i while busy is ignored; the latched sizes are unchanged.
- Asynchronous reset mid-operation drops core_start_o immediately. The core must itself return to idle on start low.

Test Plan:
- ad=16, di=24: 5 reads at addrs 0..4. AD blocks go to the core in order, then DI blocks. 3 output pulses write addrs 0,1,2. tag latched; done_o exactly 1 cycle; core_start_o falls in Finish.
- ad=0, di=0: no reads, no output writes. core_start_o high until core_tag_valid_i, then done_o.
- ad=5, di=9: n_ad=1, n_di=2; 3 reads (addrs 0,1,2); 2 output writes.
- core_data_ready_i held low 20 cycles in Present: core_data_o and core_data_valid_o stay stable throughout. A single transfer occurs when ready rises; no duplicate block is sent.
- abort_i during the 2nd DI block of ad=8, di=32: next cycle core_start_o=0; aborted_o once core_idle_i=1. No done_o; tag_valid_o=0.
- go_i pulsed while busy, and rst_n asserted mid-AD: sizes unchanged; after reset all outputs 0, FSM in Idle, and a following go_i runs normally.
